core_data_iso_buffer: RTL and testbench

Registered request stage between a cluster core's data port and the cluster data interconnect. It carries `core_data_req_t` / `core_data_rsp_t` from `pulp_cluster_package` and caps in-flight transactions at `MaxOutstanding`. It also provides a drain/isolate handshake so the HMR unit can quiesce a core before a rapid-recovery restore. One instance sits per core, directly downstream of the core data port.

---
 rtl/pulp_cluster_package.sv | 16 +
 rtl/core_data_req_slot.sv | 18 +
 rtl/core_data_iso_buffer.sv | 68 ++++++
 tb/tb_core_data_iso_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulp_cluster_package.sv
// pulp_cluster_package: core data port request/response types and isolation FSM states
package pulp_cluster_package;
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;
  typedef struct packed {
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_data;
  } core_data_rsp_t;
  typedef enum logic [1:0] {ISO_ACTIVE, ISO_DRAIN, ISO_ISOLATED} core_iso_state_e;
endpackage

// File: rtl/core_data_req_slot.sv
// core_data_req_slot: one-entry request register; req bit doubles as the valid flag
module core_data_req_slot
  import pulp_cluster_package::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load,
  input  logic           clear,
  input  core_data_req_t req_in,
  output core_data_req_t req_out
);
  // load wins over clear so a drain and refill can happen in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) req_out <= '0;
    else if (load) req_out <= req_in;
    else if (clear) req_out.req <= 1'b0;
  end
endmodule

// File: rtl/core_data_iso_buffer.sv
// core_data_iso_buffer: registered core data request stage with credit limit and drain/isolate handshake
module core_data_iso_buffer
  import pulp_cluster_package::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  core_data_req_t      core_req_i,
  output core_data_rsp_t      core_rsp_o,
  output core_data_req_t      mem_req_o,
  input  core_data_rsp_t      mem_rsp_i,
  input  logic                isolate_i,
  output logic                isolated_o,
  output logic [CntWidth-1:0] outstanding_o
);
  core_iso_state_e state, state_d;
  logic [CntWidth-1:0] cnt;
  logic buf_valid, accept, issue, retire;
  assign buf_valid = mem_req_o.req;
  assign issue     = buf_valid & mem_rsp_i.gnt;
  assign retire    = mem_rsp_i.r_valid & (cnt != '0);
  assign accept    = core_req_i.req & (state == ISO_ACTIVE) & (~buf_valid | mem_rsp_i.gnt)
                   & (32'(cnt) + 32'(buf_valid) < MaxOutstanding);
  assign core_rsp_o    = '{gnt: accept, r_valid: mem_rsp_i.r_valid, r_data: mem_rsp_i.r_data};
  assign outstanding_o = cnt;

  core_data_req_slot u_slot (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (accept),
    .clear  (issue),
    .req_in (core_req_i),
    .req_out(mem_req_o)
  );

  // outstanding count: +1 per downstream grant, -1 per response, saturating at zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else cnt <= cnt + CntWidth'(issue) - CntWidth'(retire);
  end

  // isolation state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ISO_ACTIVE;
    else state <= state_d;
  end

  // next state: dropping isolate always returns to ACTIVE; DRAIN waits for an empty stage
  always_comb begin
    state_d = (state == ISO_ACTIVE) ? (isolate_i ? ISO_DRAIN : ISO_ACTIVE)
            : !isolate_i ? ISO_ACTIVE
            : (state == ISO_DRAIN && !buf_valid && cnt == '0) ? ISO_ISOLATED
            : state;
  end

  // isolated flag decoded from the registered state
  always_comb begin
    isolated_o = (state == ISO_ISOLATED);
  end

  // a response with nothing outstanding breaks the in-order protocol
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(mem_rsp_i.r_valid && cnt == '0))
      else $warning("core_data_iso_buffer: r_valid with no outstanding request");
  end
endmodule

// File: tb/tb_core_data_iso_buffer.sv
// tb_core_data_iso_buffer: table-driven and directed checks of the isolation buffer
module tb_core_data_iso_buffer;
  import pulp_cluster_package::*;
  logic           clk_i = 1'b0;
  logic           rst_i;
  core_data_req_t core_req_i;
  core_data_rsp_t core_rsp_o;
  core_data_req_t mem_req_o;
  core_data_rsp_t mem_rsp_i;
  logic           isolate_i;
  logic           isolated_o;
  logic [2:0]     outstanding_o;
  int checks = 0;
  int errors = 0;

  core_data_iso_buffer #(.MaxOutstanding(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_rsp_o   (core_rsp_o),
    .mem_req_o    (mem_req_o),
    .mem_rsp_i    (mem_rsp_i),
    .isolate_i    (isolate_i),
    .isolated_o   (isolated_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic req;
    logic gnt;
    logic rv;
    logic eg;
    logic emq;
    int   ecnt;
    int   esrc;
  } vec_t;
  vec_t tbl[20];

  function automatic logic [31:0] a(input int k);
    return 32'h1000_0010 + 32'(k) * 16;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r, input logic g, input logic v, input logic iso);
    core_req_i.req    = r;
    mem_rsp_i.gnt     = g;
    mem_rsp_i.r_valid = v;
    isolate_i         = iso;
    #1;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] dn_add[$];
    int dn_due[$];
    int sent, got, peak;
    logic rv;
    tbl[0]  = '{1, 0, 0, 1, 0, 0, -1};
    tbl[1]  = '{0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 1, 1, 0, 4};
    tbl[6]  = '{1, 1, 0, 1, 1, 1, 5};
    tbl[7]  = '{1, 1, 0, 1, 1, 2, 6};
    tbl[8]  = '{1, 1, 0, 0, 1, 3, 7};
    tbl[9]  = '{1, 1, 0, 0, 0, 4, 7};
    tbl[10] = '{1, 1, 1, 0, 0, 4, 7};
    tbl[11] = '{1, 1, 0, 1, 0, 3, 7};
    tbl[12] = '{0, 0, 1, 0, 1, 3, 11};
    tbl[13] = '{1, 1, 1, 1, 1, 2, 11};
    tbl[14] = '{0, 0, 0, 0, 1, 2, 13};
    tbl[15] = '{0, 1, 0, 0, 1, 2, 13};
    tbl[16] = '{0, 0, 1, 0, 0, 3, 13};
    tbl[17] = '{0, 0, 1, 0, 0, 2, 13};
    tbl[18] = '{0, 0, 1, 0, 0, 1, 13};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 13};
    rst_i      = 1'b1;
    core_req_i = '0;
    mem_rsp_i  = '0;
    isolate_i  = 1'b0;
    #1;
    chk("rst_mem_req", mem_req_o, '0);
    chk("rst_cnt", 32'(outstanding_o), 0);
    chk("rst_isolated", 32'(isolated_o), 0);
    chk("rst_gnt", 32'(core_rsp_o.gnt), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      core_req_i = '{req: tbl[i].req, add: a(i), we: 1'(i % 2), data: ~a(i), be: 4'hF};
      mem_rsp_i  = '{gnt: tbl[i].gnt, r_valid: tbl[i].rv, r_data: a(i) ^ 32'hA5A5_0000};
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(core_rsp_o.gnt), 32'(tbl[i].eg));
      chk($sformatf("v%0d_mreq", i), 32'(mem_req_o.req), 32'(tbl[i].emq));
      chk($sformatf("v%0d_cnt", i), 32'(outstanding_o), tbl[i].ecnt);
      chk($sformatf("v%0d_add", i), mem_req_o.add, tbl[i].esrc < 0 ? 32'h0 : a(tbl[i].esrc));
      chk($sformatf("v%0d_data", i), mem_req_o.data, tbl[i].esrc < 0 ? 32'h0 : ~a(tbl[i].esrc));
      chk($sformatf("v%0d_rvalid", i), 32'(core_rsp_o.r_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rdata", i), core_rsp_o.r_data, a(i) ^ 32'hA5A5_0000);
      chk($sformatf("v%0d_iso", i), 32'(isolated_o), 0);
      step;
    end
    sent = 0;
    got  = 0;
    peak = 0;
    for (int c = 0; c < 80 && got < 16; c++) begin
      core_req_i = '{req: (sent < 16), add: 32'h2000_0000 + 32'(sent) * 4, we: 1'b0, data: 32'h0, be: 4'hF};
      rv = dn_due.size() > 0 && dn_due[0] == c;
      mem_rsp_i = '{gnt: 1'b1, r_valid: rv, r_data: rv ? dn_add[0] : 32'h0};
      if (rv) begin
        void'(dn_due.pop_front());
        void'(dn_add.pop_front());
      end
      #1;
      if (core_rsp_o.gnt) begin
        exp_q.push_back(core_req_i.add);
        sent++;
      end
      if (core_rsp_o.r_valid) begin
        chk("stream_rdata", core_rsp_o.r_data, exp_q.size() > 0 ? exp_q.pop_front() : 32'hX);
        got++;
      end
      if (mem_req_o.req) begin
        dn_add.push_back(mem_req_o.add);
        dn_due.push_back(c + 3);
      end
      if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
      step;
    end
    chk("stream_sent", sent, 16);
    chk("stream_got", got, 16);
    chk("stream_peak", peak, 3);
    core_req_i = '{req: 1'b0, add: 32'h3000_0000, we: 1'b1, data: 32'h1234_5678, be: 4'h3};
    drive(0, 0, 0, 0);
    chk("iso_start_cnt", 32'(outstanding_o), 0);
    step;
    drive(1, 1, 0, 0);
    chk("iso_a_gnt", 32'(core_rsp_o.gnt), 1);
    step;
    drive(1, 1, 0, 0);
    step;
    drive(1, 1, 0, 0);
    step;
    drive(1, 0, 0, 1);
    chk("iso_d_gnt", 32'(core_rsp_o.gnt), 0);
    chk("iso_d_cnt", 32'(outstanding_o), 2);
    chk("iso_d_mreq", 32'(mem_req_o.req), 1);
    step;
    drive(1, 1, 0, 1);
    chk("iso_e_gnt", 32'(core_rsp_o.gnt), 0);
    chk("iso_e_mreq", 32'(mem_req_o.req), 1);
    chk("iso_e_iso", 32'(isolated_o), 0);
    step;
    drive(1, 0, 1, 1);
    chk("iso_f_cnt", 32'(outstanding_o), 3);
    chk("iso_f_mreq", 32'(mem_req_o.req), 0);
    chk("iso_f_gnt", 32'(core_rsp_o.gnt), 0);
    step;
    drive(1, 0, 1, 1);
    step;
    drive(1, 0, 1, 1);
    chk("iso_h_cnt", 32'(outstanding_o), 1);
    chk("iso_h_iso", 32'(isolated_o), 0);
    step;
    drive(1, 0, 0, 1);
    chk("iso_i_cnt", 32'(outstanding_o), 0);
    chk("iso_i_iso", 32'(isolated_o), 0);
    chk("iso_i_gnt", 32'(core_rsp_o.gnt), 0);
    step;
    drive(1, 0, 0, 1);
    chk("iso_j_iso", 32'(isolated_o), 1);
    chk("iso_j_gnt", 32'(core_rsp_o.gnt), 0);
    step;
    drive(1, 0, 0, 0);
    chk("iso_k_iso", 32'(isolated_o), 1);
    chk("iso_k_gnt", 32'(core_rsp_o.gnt), 0);
    step;
    drive(1, 0, 0, 0);
    chk("iso_l_iso", 32'(isolated_o), 0);
    chk("iso_l_gnt", 32'(core_rsp_o.gnt), 1);
    step;
    chk("iso_l_add", mem_req_o.add, 32'h3000_0000);
    chk("iso_l_be", 32'(mem_req_o.be), 32'h3);
    drive(1, 1, 0, 0);
    step;
    drive(1, 1, 0, 0);
    step;
    drive(1, 1, 0, 0);
    step;
    drive(0, 0, 0, 0);
    chk("rst_pre_cnt", 32'(outstanding_o), 3);
    chk("rst_pre_mreq", 32'(mem_req_o.req), 1);
    rst_i = 1'b1;
    #1;
    chk("rst_async_cnt", 32'(outstanding_o), 0);
    chk("rst_async_mreq", mem_req_o, '0);
    chk("rst_async_iso", 32'(isolated_o), 0);
    step;
    rst_i = 1'b0;
    drive(0, 0, 1, 0);
    chk("stray_cnt_before", 32'(outstanding_o), 0);
    step;
    drive(0, 0, 0, 0);
    chk("stray_cnt_after", 32'(outstanding_o), 0);
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
